// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects a 4-byte command frame (opcode, A, B, flags),
// issues it to the alu with a one-cycle strobe, waits for the result with a
// timeout, and returns a 2-byte response frame (result, status).
//
// Handshake rule for both byte streams: a byte moves on a rising clk edge
// where valid and ready are both high. A producer holding valid keeps its
// data stable until that edge; ready may be low at any time.
module alu_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_OPCODE     = 19,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [4:0] alu_opcode_o,
  output logic [7:0] alu_operand_a_o,
  output logic [7:0] alu_operand_b_o,
  output logic       alu_carry_in_o,
  output logic       alu_borrow_in_o,
  output logic       alu_enable_o,
  output logic       alu_input_ready_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_result_ready_i,
  input  logic       alu_carry_out_i,
  input  logic       alu_borrow_out_i,
  input  logic       alu_zero_i,
  input  logic       alu_negative_i,
  input  logic       alu_overflow_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_A     = 3'd1,
    S_B     = 3'd2,
    S_FLG   = 3'd3,
    S_ISSUE = 3'd4,
    S_WAIT  = 3'd5,
    S_RES   = 3'd6,
    S_STAT  = 3'd7
  } state_t;

  localparam logic [4:0]       MAX_OP  = MAX_OPCODE[4:0];
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [4:0]       opcode_q;
  logic [7:0]       a_q, b_q;
  logic             cin_q, bin_q;
  logic [7:0]       result_q;
  logic [4:0]       flags_q;   // {overflow, negative, zero, borrow, carry}
  logic             err_op_q, err_to_q;
  logic [CNT_W-1:0] cnt_q;
  logic             en_q;
  logic             accept;
  logic             op_bad;
  logic             timeout;

  assign accept  = in_valid_i && in_ready_o;
  assign op_bad  = (opcode_q > MAX_OP);
  assign timeout = (cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_OP;
    else     state_q <= state_d;
  end

  // Next-state logic; a result arriving on the timeout cycle wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OP:    if (accept) state_d = S_A;
      S_A:     if (accept) state_d = S_B;
      S_B:     if (accept) state_d = S_FLG;
      S_FLG:   if (accept) state_d = op_bad ? S_RES : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (alu_result_ready_i || timeout) state_d = S_RES;
      S_RES:   if (out_ready_i) state_d = S_STAT;
      S_STAT:  if (out_ready_i) state_d = S_OP;
      default: state_d = S_OP;
    endcase
  end

  // Frame capture, result capture, timeout counter and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      bin_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      err_op_q <= 1'b0;
      err_to_q <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      en_q <= 1'b1;
      case (state_q)
        S_OP: if (accept) opcode_q <= in_data_i[4:0];
        S_A:  if (accept) a_q <= in_data_i;
        S_B:  if (accept) b_q <= in_data_i;
        S_FLG: begin
          if (accept) begin
            cin_q <= in_data_i[0];
            bin_q <= in_data_i[1];
            if (op_bad) begin
              err_op_q <= 1'b1;
              result_q <= '0;
              flags_q  <= '0;
            end
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          if (alu_result_ready_i) begin
            result_q <= alu_result_i;
            flags_q  <= {alu_overflow_i, alu_negative_i, alu_zero_i,
                         alu_borrow_out_i, alu_carry_out_i};
          end else if (timeout) begin
            err_to_q <= 1'b1;
            result_q <= '0;
            flags_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STAT: begin
          if (out_ready_i) begin
            err_op_q <= 1'b0;
            err_to_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and held registers.
  always_comb begin
    in_ready_o        = 1'b0;
    alu_input_ready_o = 1'b0;
    out_valid_o       = 1'b0;
    out_data_o        = 8'h00;
    busy_o            = (state_q != S_OP);
    case (state_q)
      S_OP, S_A, S_B, S_FLG: in_ready_o = !rst;
      S_ISSUE: alu_input_ready_o = 1'b1;
      S_RES: begin
        out_valid_o = 1'b1;
        out_data_o  = result_q;
      end
      S_STAT: begin
        out_valid_o = 1'b1;
        out_data_o  = {1'b0, err_to_q, err_op_q, flags_q};
      end
      default: ;
    endcase
  end

  assign alu_opcode_o    = opcode_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;
  assign alu_carry_in_o  = cin_q;
  assign alu_borrow_in_o = bin_q;
  assign alu_enable_o    = en_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a programmable stub alu.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] alu_opcode;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin, alu_bin, alu_en, alu_strobe;
  logic [7:0] alu_result;
  logic       alu_rr;
  logic       alu_co, alu_bo, alu_z, alu_n, alu_v;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;

  // Stub alu configuration, driven by the tests.
  logic [7:0] stub_result = 8'h00;
  logic [4:0] stub_flags  = 5'h00;  // {v, n, z, borrow, carry}
  int         stub_delay  = 1;
  logic       stub_never  = 1'b0;

  // Stub alu state.
  int         pend = 0;
  int         strobes = 0;
  logic [4:0] cap_op = '0;
  logic [7:0] cap_a = '0, cap_b = '0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_opcode_o(alu_opcode), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_carry_in_o(alu_cin), .alu_borrow_in_o(alu_bin),
    .alu_enable_o(alu_en), .alu_input_ready_o(alu_strobe),
    .alu_result_i(alu_result), .alu_result_ready_i(alu_rr),
    .alu_carry_out_i(alu_co), .alu_borrow_out_i(alu_bo), .alu_zero_i(alu_z),
    .alu_negative_i(alu_n), .alu_overflow_i(alu_v),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  // Stub alu: answers stub_delay cycles after each strobe (or never).
  always @(posedge clk) begin
    if (rst) begin
      pend <= 0;
    end else if (alu_strobe) begin
      strobes <= strobes + 1;
      cap_op  <= alu_opcode;
      cap_a   <= alu_a;
      cap_b   <= alu_b;
      pend    <= stub_never ? 0 : stub_delay;
    end else if (pend != 0) begin
      pend <= pend - 1;
    end
  end

  assign alu_rr     = (pend == 1);
  assign alu_result = stub_result;
  assign {alu_v, alu_n, alu_z, alu_bo, alu_co} = stub_flags;

  // Offer one byte and hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_byte_timeout: in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  // Accept one response byte; ok=0 if none appeared within the bound.
  task automatic recv_byte(output logic [7:0] b, output logic ok);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    b  = out_data;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, alu_en, out_valid, out_data, alu_strobe, busy} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%0b en=%0b ov=%0b od=%h stb=%0b busy=%0b required all 0",
               in_ready, alu_en, out_valid, out_data, alu_strobe, busy);
    end
    checks++;
    if ({alu_opcode, alu_a, alu_b, alu_cin, alu_bin} !== 23'h0) begin
      failures++;
      $display("FAIL reset_operands: op=%h a=%h b=%h cin=%0b bin=%0b required 0",
               alu_opcode, alu_a, alu_b, alu_cin, alu_bin);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || alu_en !== 1'b1 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL after_reset: rdy=%0b en=%0b state=%0d required 1 1 0",
               in_ready, alu_en, dbg_state);
    end
  endtask

  // 00,05,03,00 -> 0x08, status 0x00; also checks issue latency.
  task automatic test_add();
    logic [7:0] b;
    logic ok;
    int s0;
    s0 = strobes;
    stub_result = 8'h08; stub_flags = 5'h00; stub_delay = 1; stub_never = 1'b0;
    send_frame(8'h00, 8'h05, 8'h03, 8'h00);
    @(negedge clk);
    checks++;
    if (alu_strobe !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL add_issue_cycle: stb=%0b ov=%0b busy=%0b required 1 0 1",
               alu_strobe, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (alu_strobe !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_wait_cycle: stb=%0b ov=%0b required 0 0", alu_strobe, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h08) begin
      failures++;
      $display("FAIL add_latency: ov=%0b od=%h required 1 08", out_valid, out_data);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h08) begin
      failures++;
      $display("FAIL add_result: got=%h ok=%0b required 08", b, ok);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h00) begin
      failures++;
      $display("FAIL add_status: got=%h ok=%0b required 00", b, ok);
    end
    checks++;
    if (strobes - s0 !== 1 || cap_op !== 5'h00 || cap_a !== 8'h05 || cap_b !== 8'h03) begin
      failures++;
      $display("FAIL add_issue: strobes=%0d op=%h a=%h b=%h required 1 00 05 03",
               strobes - s0, cap_op, cap_a, cap_b);
    end
  endtask

  // 00,7F,01,00 with alu answering 0x00, carry and overflow -> status 0x11.
  task automatic test_flags();
    logic [7:0] b;
    logic ok;
    stub_result = 8'h00; stub_flags = 5'b10001; stub_delay = 1;
    send_frame(8'h00, 8'h7F, 8'h01, 8'h00);
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h00) begin
      failures++;
      $display("FAIL flags_result: got=%h ok=%0b required 00", b, ok);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h11) begin
      failures++;
      $display("FAIL flags_status: got=%h ok=%0b required 11", b, ok);
    end
  endtask

  // 1F,11,22,00: illegal opcode, no strobe, 0x00 then 0x20.
  task automatic test_bad_opcode();
    logic [7:0] b;
    logic ok;
    int s0;
    s0 = strobes;
    stub_result = 8'hEE; stub_flags = 5'h1F;
    send_frame(8'h1F, 8'h11, 8'h22, 8'h00);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || alu_strobe !== 1'b0) begin
      failures++;
      $display("FAIL badop_skip: ov=%0b stb=%0b required 1 0", out_valid, alu_strobe);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h00) begin
      failures++;
      $display("FAIL badop_result: got=%h ok=%0b required 00", b, ok);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h20) begin
      failures++;
      $display("FAIL badop_status: got=%h ok=%0b required 20", b, ok);
    end
    checks++;
    if (strobes !== s0) begin
      failures++;
      $display("FAIL badop_strobe: strobes=%0d required %0d", strobes, s0);
    end
  endtask

  // Alu never answers: RES after 16 WAIT cycles, 0x00 then 0x40.
  task automatic test_timeout();
    logic [7:0] b;
    logic ok;
    int n;
    stub_result = 8'h99; stub_flags = 5'h1F; stub_never = 1'b1;
    send_frame(8'h01, 8'h10, 8'h20, 8'h00);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 18) begin
      failures++;
      $display("FAIL timeout_cycles: negedges=%0d required 18", n);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h00) begin
      failures++;
      $display("FAIL timeout_result: got=%h ok=%0b required 00", b, ok);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h40) begin
      failures++;
      $display("FAIL timeout_status: got=%h ok=%0b required 40", b, ok);
    end
    stub_never = 1'b0;
  endtask

  // out_ready held low in RES while upstream keeps offering a byte.
  task automatic test_backpressure();
    logic [7:0] b;
    logic ok;
    int n;
    int bad;
    stub_result = 8'hA5; stub_flags = 5'b00110; stub_delay = 2;
    send_frame(8'h02, 8'h33, 8'h44, 8'h00);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_data  = 8'h55;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable: bad_cycles=%0d ov=%0b od=%h rdy=%0b required 0 1 a5 0",
               bad, out_valid, out_data, in_ready);
    end
    in_valid = 1'b0;
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hA5) begin
      failures++;
      $display("FAIL hold_result: got=%h ok=%0b required a5", b, ok);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h06) begin
      failures++;
      $display("FAIL hold_status: got=%h ok=%0b required 06", b, ok);
    end
  endtask

  // Reset after byte A, then 08,F0,3C,00 -> single response 0x30 / 0x00.
  task automatic test_reset_midframe();
    logic [7:0] b;
    logic ok;
    int s0;
    send_byte(8'h03);
    send_byte(8'h77);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || alu_en !== 1'b0 || alu_a !== 8'h00 ||
        alu_opcode !== 5'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: rdy=%0b busy=%0b en=%0b a=%h op=%h ov=%0b required 0 0 0 00 00 0",
               in_ready, busy, alu_en, alu_a, alu_opcode, out_valid);
    end
    rst = 1'b0;
    s0 = strobes;
    stub_result = 8'h30; stub_flags = 5'h00; stub_delay = 1;
    send_frame(8'h08, 8'hF0, 8'h3C, 8'h00);
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h30) begin
      failures++;
      $display("FAIL midrst_result: got=%h ok=%0b required 30", b, ok);
    end
    recv_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h00) begin
      failures++;
      $display("FAIL midrst_status: got=%h ok=%0b required 00", b, ok);
    end
    checks++;
    if (strobes - s0 !== 1 || cap_op !== 5'h08 || cap_a !== 8'hF0 || cap_b !== 8'h3C) begin
      failures++;
      $display("FAIL midrst_issue: strobes=%0d op=%h a=%h b=%h required 1 08 f0 3c",
               strobes - s0, cap_op, cap_a, cap_b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle: ov=%0b busy=%0b required 0 0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_bad_opcode();
    test_timeout();
    test_backpressure();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
